// File: rtl/port_wr_sram_matcher_v2.sv
// port_wr_sram_matcher_v2: keeps the best fitting SRAM seen during a round-robin scan
// and reports success after the threshold, or failure on timeout.
module port_wr_sram_matcher_v2 #(
  parameter int SRAM_NUM = 32,
  parameter int IDX_W    = 6,
  parameter int SPACE_W  = 11,
  parameter int AMOUNT_W = 9,
  parameter int LEN_W    = 6,
  parameter int TICK_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [TICK_W-1:0]   match_threshold,
  input  logic [TICK_W-1:0]   match_timeout,
  input  logic                tie_prefer_new,
  input  logic [LEN_W-1:0]    new_length,
  input  logic                match_enable,
  output logic                match_suc,
  output logic                match_fail,
  output logic                match_busy,
  output logic [IDX_W-1:0]    match_best_sram,
  output logic [AMOUNT_W-1:0] match_best_amount,
  input  logic [IDX_W-1:0]    match_sram,
  input  logic                accessible,
  input  logic [SPACE_W-1:0]  free_space,
  input  logic [AMOUNT_W-1:0] packet_amount
);
  localparam int CW = (SPACE_W > LEN_W + 1 ? SPACE_W : LEN_W + 1) + 1;
  localparam logic [IDX_W-1:0] NONE = IDX_W'(SRAM_NUM);
  typedef enum logic [1:0] {IDLE, SCAN, DONE, FAIL} state_t;
  state_t state, state_n;
  logic [TICK_W-1:0] tick;
  logic find, fit, better, find_n;
  logic [IDX_W-1:0] best_sram;
  logic [AMOUNT_W-1:0] best_amount;
  always_comb begin
    fit = accessible && (CW'(free_space) >= CW'(new_length) + CW'(1));
    better = fit && (!find || packet_amount > best_amount || (packet_amount == best_amount && tie_prefer_new));
    find_n = find || better;
  end
  // enable drop outranks both success and timeout
  always_comb begin
    state_n = state == IDLE ? (match_enable ? SCAN : IDLE) :
              state == SCAN ? (!match_enable ? IDLE :
                               find_n && tick >= match_threshold ? DONE :
                               !find_n && tick >= match_timeout ? FAIL : SCAN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      tick <= '0;
      find <= 1'b0;
      best_sram <= NONE;
      best_amount <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && match_enable) begin
        tick <= '0;
        find <= 1'b0;
        best_sram <= NONE;
        best_amount <= '0;
      end else if (state == SCAN && !match_enable) begin
        find <= 1'b0;
        best_sram <= NONE;
        best_amount <= '0;
      end else if (state == SCAN) begin
        tick <= &tick ? tick : tick + 1'b1;
        if (better) begin
          find <= 1'b1;
          best_sram <= match_sram;
          best_amount <= packet_amount;
        end
      end
    end
  end
  always_comb begin
    match_suc = state == DONE;
    match_fail = state == FAIL;
    match_busy = state == SCAN;
    match_best_sram = best_sram;
    match_best_amount = best_amount;
  end
endmodule

// File: tb/tb_port_wr_sram_matcher_v2.sv
// tb_port_wr_sram_matcher_v2: directed scenarios for the SRAM matcher, default and 16-SRAM builds.
module tb_port_wr_sram_matcher_v2;
  logic clk = 0, rst_n = 0;
  logic [7:0] match_threshold = 0, match_timeout = 0;
  logic tie_prefer_new = 0, match_enable = 0, accessible = 0;
  logic [5:0] new_length = 0, match_sram = 0;
  logic [10:0] free_space = 0;
  logic [8:0] packet_amount = 0;
  logic match_suc, match_fail, match_busy, s_suc, s_fail, s_busy;
  logic [5:0] match_best_sram;
  logic [4:0] s_best_sram;
  logic [8:0] match_best_amount, s_best_amount;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  port_wr_sram_matcher_v2 dut (
    .clk(clk), .rst_n(rst_n), .match_threshold(match_threshold), .match_timeout(match_timeout),
    .tie_prefer_new(tie_prefer_new), .new_length(new_length), .match_enable(match_enable),
    .match_suc(match_suc), .match_fail(match_fail), .match_busy(match_busy),
    .match_best_sram(match_best_sram), .match_best_amount(match_best_amount),
    .match_sram(match_sram), .accessible(accessible), .free_space(free_space),
    .packet_amount(packet_amount)
  );

  port_wr_sram_matcher_v2 #(.SRAM_NUM(16), .IDX_W(5)) dut_s (
    .clk(clk), .rst_n(rst_n), .match_threshold(match_threshold), .match_timeout(match_timeout),
    .tie_prefer_new(tie_prefer_new), .new_length(new_length), .match_enable(match_enable),
    .match_suc(s_suc), .match_fail(s_fail), .match_busy(s_busy),
    .match_best_sram(s_best_sram), .match_best_amount(s_best_amount),
    .match_sram(match_sram[4:0]), .accessible(accessible), .free_space(free_space),
    .packet_amount(packet_amount)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cand(input int idx, input bit acc, input int fs, input int amt);
    match_sram = 6'(idx);
    accessible = acc;
    free_space = 11'(fs);
    packet_amount = 9'(amt);
  endtask

  task automatic go_idle();
    match_enable = 0;
    cand(0, 0, 0, 0);
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 0;
    step();
    step();
    checks++;
    if ({match_suc, match_fail, match_busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000", {match_suc, match_fail, match_busy});
    end
    checks++;
    if (match_best_sram !== 6'd32 || match_best_amount !== 9'd0) begin
      errors++;
      $display("FAIL reset_best got %0d/%0d want 32/0", match_best_sram, match_best_amount);
    end
    checks++;
    if (s_best_sram !== 5'd16 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_small got %0d busy %b want 16 busy 0", s_best_sram, s_busy);
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_tie(input bit tp, input int exp_sram);
    match_threshold = 3;
    match_timeout = 20;
    tie_prefer_new = tp;
    new_length = 4;
    match_enable = 1;
    step();
    checks++;
    if (match_busy !== 1'b1) begin
      errors++;
      $display("FAIL tie%0d_busy got %b want 1", tp, match_busy);
    end
    cand(4, 1, 100, 5);
    step();
    cand(7, 1, 100, 12);
    step();
    cand(9, 1, 100, 12);
    step();
    checks++;
    if (match_suc !== 1'b0) begin
      errors++;
      $display("FAIL tie%0d_early got %b want 0", tp, match_suc);
    end
    cand(2, 1, 100, 3);
    step();
    checks++;
    if (match_suc !== 1'b1 || match_busy !== 1'b0) begin
      errors++;
      $display("FAIL tie%0d_suc got suc %b busy %b want 1 0", tp, match_suc, match_busy);
    end
    checks++;
    if (match_best_sram !== 6'(exp_sram) || match_best_amount !== 9'd12) begin
      errors++;
      $display("FAIL tie%0d_best got %0d/%0d want %0d/12", tp, match_best_sram, match_best_amount, exp_sram);
    end
    match_enable = 0;
    step();
    checks++;
    if (match_suc !== 1'b0 || match_best_sram !== 6'(exp_sram)) begin
      errors++;
      $display("FAIL tie%0d_after got suc %b best %0d want 0 %0d", tp, match_suc, match_best_sram, exp_sram);
    end
    go_idle();
  endtask

  task automatic test_fit_fail();
    match_threshold = 0;
    match_timeout = 5;
    tie_prefer_new = 0;
    new_length = 10;
    match_enable = 1;
    step();
    cand(5, 1, 10, 1);
    step();
    checks++;
    if (match_suc !== 1'b0 || match_busy !== 1'b1) begin
      errors++;
      $display("FAIL fit_reject10 got suc %b busy %b want 0 1", match_suc, match_busy);
    end
    cand(6, 0, 500, 1);
    for (int i = 1; i <= 4; i++) step();
    checks++;
    if (match_fail !== 1'b0) begin
      errors++;
      $display("FAIL fail_early got %b want 0", match_fail);
    end
    step();
    checks++;
    if (match_fail !== 1'b1 || match_suc !== 1'b0 || match_best_sram !== 6'd32) begin
      errors++;
      $display("FAIL fail_pulse got fail %b suc %b best %0d want 1 0 32", match_fail, match_suc, match_best_sram);
    end
    match_enable = 0;
    step();
    checks++;
    if (match_fail !== 1'b0) begin
      errors++;
      $display("FAIL fail_drop got %b want 0", match_fail);
    end
    step();
    match_enable = 1;
    step();
    cand(5, 1, 11, 2);
    step();
    checks++;
    if (match_suc !== 1'b1 || match_best_sram !== 6'd5) begin
      errors++;
      $display("FAIL fit_accept11 got suc %b best %0d want 1 5", match_suc, match_best_sram);
    end
    go_idle();
    new_length = 63;
    match_enable = 1;
    step();
    cand(3, 1, 63, 1);
    step();
    checks++;
    if (match_suc !== 1'b0) begin
      errors++;
      $display("FAIL fit_max_reject got %b want 0", match_suc);
    end
    cand(6, 1, 64, 1);
    step();
    checks++;
    if (match_suc !== 1'b1 || match_best_sram !== 6'd6) begin
      errors++;
      $display("FAIL fit_max_accept got suc %b best %0d want 1 6", match_suc, match_best_sram);
    end
    go_idle();
  endtask

  task automatic test_late_find();
    match_threshold = 4;
    match_timeout = 20;
    new_length = 4;
    match_enable = 1;
    step();
    cand(1, 0, 100, 1);
    for (int i = 0; i <= 8; i++) step();
    checks++;
    if (match_suc !== 1'b0 || match_busy !== 1'b1) begin
      errors++;
      $display("FAIL late_wait got suc %b busy %b want 0 1", match_suc, match_busy);
    end
    cand(11, 1, 100, 7);
    step();
    checks++;
    if (match_suc !== 1'b1 || match_best_sram !== 6'd11 || match_best_amount !== 9'd7) begin
      errors++;
      $display("FAIL late_suc got suc %b best %0d/%0d want 1 11/7", match_suc, match_best_sram, match_best_amount);
    end
    go_idle();
  endtask

  task automatic test_abort();
    match_threshold = 10;
    match_timeout = 20;
    match_enable = 1;
    step();
    cand(3, 1, 100, 9);
    step();
    step();
    match_enable = 0;
    step();
    checks++;
    if ({match_suc, match_fail, match_busy} !== 3'b000) begin
      errors++;
      $display("FAIL abort_flags got %b want 000", {match_suc, match_fail, match_busy});
    end
    checks++;
    if (match_best_sram !== 6'd32 || match_best_amount !== 9'd0) begin
      errors++;
      $display("FAIL abort_best got %0d/%0d want 32/0", match_best_sram, match_best_amount);
    end
    match_threshold = 0;
    match_timeout = 2;
    cand(3, 0, 100, 9);
    match_enable = 1;
    step();
    step();
    step();
    checks++;
    if (match_fail !== 1'b0 || match_suc !== 1'b0) begin
      errors++;
      $display("FAIL restart_early got fail %b suc %b want 0 0", match_fail, match_suc);
    end
    step();
    checks++;
    if (match_fail !== 1'b1) begin
      errors++;
      $display("FAIL restart_fail got %b want 1", match_fail);
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    match_threshold = 10;
    match_timeout = 20;
    match_enable = 1;
    step();
    cand(8, 1, 100, 4);
    step();
    step();
    rst_n = 0;
    step();
    checks++;
    if ({match_suc, match_fail, match_busy} !== 3'b000 || match_best_sram !== 6'd32 || match_best_amount !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid got flags %b best %0d/%0d want 000 32/0", {match_suc, match_fail, match_busy}, match_best_sram, match_best_amount);
    end
    checks++;
    if (s_best_sram !== 5'd16 || s_busy !== 1'b0 || s_best_amount !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid_small got %0d busy %b amt %0d want 16 0 0", s_best_sram, s_busy, s_best_amount);
    end
    rst_n = 1;
    go_idle();
  endtask

  initial begin
    test_reset();
    test_tie(0, 7);
    test_tie(1, 9);
    test_fit_fail();
    test_late_find();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/port_wr_sram_matcher_v2.md
Name: port_wr_sram_matcher_v2

Overview:
- Per-port write-side SRAM selector. One instance sits in each ingress port's write path.
- The backend scans SRAMs round-robin and presents one candidate per cycle (index, accessibility, free space, per-port packet count).
- The block keeps the best fitting SRAM seen so far and reports success once the scan has run long enough. It reports failure on timeout.
- Compared with the earlier matcher, it adds parametrised SRAM count and widths, a stored best index and amount, a tie-break mode, timeout/failure reporting, and abort on enable drop.

Parameters:
- SRAM_NUM, 32, number of SRAMs; the index value SRAM_NUM is the "none" sentinel.
- IDX_W, 6, index width; must satisfy 2^IDX_W > SRAM_NUM.
- SPACE_W, 11, free-space width (half-words).
- AMOUNT_W, 9, packet-amount width.
- LEN_W, 6, packet length width (half-words).
- TICK_W, 8, scan tick counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- match_threshold  in  TICK_W  minimum scan ticks before success may be declared.
- match_timeout  in  TICK_W  tick count at which a scan with no candidate fails; must be >= match_threshold.
- tie_prefer_new  in  1  1: an equal amount replaces the current best; 0: the first-seen candidate is kept.
- new_length  in  LEN_W  length of the packet to be written; held stable while match_enable=1.
- match_enable  in  1  level request from the frontend; held high until match_suc or match_fail.
- match_suc  out  1  one-cycle success pulse.
- match_fail  out  1  one-cycle timeout pulse.
- match_busy  out  1  high while in SCAN.
- match_best_sram  out  IDX_W  best SRAM index; valid while match_suc=1.
- match_best_amount  out  AMOUNT_W  packet_amount of the best SRAM.
- match_sram  in  IDX_W  index of the candidate presented this cycle.
- accessible  in  1  candidate SRAM is not occupied by another port.
- free_space  in  SPACE_W  candidate's free half-words.
- packet_amount  in  AMOUNT_W  candidate's packet count for this port.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, tick=0, find=0.
  - match_suc=0, match_fail=0, match_busy=0.
  - match_best_sram=SRAM_NUM, match_best_amount=0.
  - Reset during SCAN aborts the scan with no pulse.
- States: IDLE, SCAN, DONE, FAIL.
- IDLE:
  - If match_enable=1, go to SCAN.
  - On entry to SCAN: tick=0, find=0, best_sram=SRAM_NUM, best_amount=0.
- SCAN, once per cycle:
  - fit = accessible && (free_space >= new_length+1). Compare at width max(SPACE_W, LEN_W+1)+1 so new_length = 2^LEN_W-1 cannot overflow.
  - better = fit && (!find || packet_amount > best_amount || (packet_amount == best_amount && tie_prefer_new)).
  - If better: best_sram <= match_sram, best_amount <= packet_amount, find <= 1.
  - tick increments by 1 and saturates at all-ones.
  - find_n = find || better. The exit decision uses find_n, so the candidate presented in the decision cycle counts.
  - find_n && tick >= match_threshold: go to DONE and set match_suc=1 on the same edge. match_best_sram shows the final best, including that cycle's candidate.
  - Otherwise, !find_n && tick >= match_timeout: go to FAIL and set match_fail=1. match_best_sram=SRAM_NUM.
  - match_enable=0 in SCAN: go to IDLE, no pulse, best outputs return to SRAM_NUM/0. Enable drop has priority over success and fail.
- DONE / FAIL:
  - Last one cycle. The pulse drops on the next edge and the state returns to IDLE.
  - Best outputs hold until the next SCAN entry.
  - A new scan needs match_enable sampled high in IDLE. This gives at least one idle cycle between requests.
- Thresholds:
  - match_threshold=0 allows success in the first SCAN cycle.
  - match_timeout < match_threshold is illegal. If it occurs, the fail rule still applies at tick >= match_timeout.
- Latency:
  - Enable high at edge N gives SCAN at N+1.
  - The earliest match_suc is at edge N+1+match_threshold+1.
- match_busy = (state==SCAN).
- The block does not check candidate indices for duplicates. Repeated indices are evaluated independently.

Test Plan:
- threshold=3, timeout=20. Candidates idx 4, 7, 9, 2 with amounts 5, 12, 12, 3, all fitting, tie_prefer_new=0 -> match_suc one cycle after the 4th candidate; best_sram=7, best_amount=12.
- Same stimulus with tie_prefer_new=1 -> best_sram=9, best_amount=12.
- new_length=10. Candidate free_space 10 is rejected; free_space 11 is accepted. All candidates with accessible=0 are rejected -> with timeout=5, match_fail pulses after 6 SCAN cycles; best_sram=SRAM_NUM(32).
- threshold=4 and the first fitting candidate appears only at tick 9 -> match_suc in the same cycle that candidate is presented; best_sram = its index.
- match_enable dropped at tick 2 with find=1 -> no suc/fail pulse, state IDLE, best_sram=32. Re-raising enable starts a clean scan with tick=0.
- rst_n=0 mid-SCAN -> next cycle all outputs at reset values. With SRAM_NUM=16, IDX_W=5, the sentinel reads 16.
